// File: rtl/tft_mem_resp.sv
// tft_mem_resp: burst read responder between the TFT read client and the memory read arbiter.
// Optional accepted-burst statistics counter is built when TFT_RESP_STAT_EN is defined.
module tft_mem_resp #(
    parameter int unsigned AN     = 24,
    parameter int unsigned DN     = 16,
    parameter int unsigned BURST  = 8,
    parameter int unsigned MAXOUT = 16,
    parameter int unsigned FLUSH  = 15
) (
    input  logic          clkSYS,
    input  logic          aclr,
    input  logic          req,
    input  logic [AN-1:0] req_addr,
    output logic          req_ack,
    output logic [DN-1:0] mem_data,
    output logic          mem_valid,
    output logic [AN-1:0] mrd_addr,
    output logic          mrd_req,
    input  logic          mrd_gnt,
    input  logic [DN-1:0] mrd_data,
    input  logic          mrd_valid,
    output logic          busy,
    output logic [15:0]   burst_cnt
);
    localparam int unsigned OW = $clog2(MAXOUT + 1);
    localparam int unsigned RW = $clog2(BURST + 1);
    localparam int unsigned FW = (FLUSH > 1) ? $clog2(FLUSH) : 1;

    if (BURST > MAXOUT) begin : g_bad_cfg
        $error("tft_mem_resp: BURST must not exceed MAXOUT");
    end

    typedef enum logic [1:0] {
        ST_FLUSH,
        ST_IDLE,
        ST_ISSUE
    } state_t;

    state_t        state, state_n;
    logic [FW-1:0] flush_cnt, flush_cnt_n;
    logic [RW-1:0] remaining, remaining_n;
    logic [OW-1:0] outstanding, outstanding_n;
    logic [AN-1:0] mrd_addr_n;
    logic [DN-1:0] mem_data_n;
    logic          mrd_req_n, req_ack_n, mem_valid_n, busy_n;
    logic          grant, fwd, room;

    assign grant = mrd_req && mrd_gnt;
    // Returns are only forwarded when owed; anything else is a stale word from before reset.
    assign fwd   = mrd_valid && (outstanding != '0) && (state != ST_FLUSH);
    assign room  = (32'(outstanding) + BURST) <= MAXOUT;

    always_ff @(posedge clkSYS or posedge aclr) begin
        if (aclr) begin
            state       <= ST_FLUSH;
            flush_cnt   <= '0;
            remaining   <= '0;
            outstanding <= '0;
            mrd_addr    <= '0;
            mrd_req     <= 1'b0;
            req_ack     <= 1'b0;
            mem_valid   <= 1'b0;
            mem_data    <= '0;
            busy        <= 1'b1;
        end else begin
            state       <= state_n;
            flush_cnt   <= flush_cnt_n;
            remaining   <= remaining_n;
            outstanding <= outstanding_n;
            mrd_addr    <= mrd_addr_n;
            mrd_req     <= mrd_req_n;
            req_ack     <= req_ack_n;
            mem_valid   <= mem_valid_n;
            mem_data    <= mem_data_n;
            busy        <= busy_n;
        end
    end

    always_comb begin
        state_n     = state;
        flush_cnt_n = flush_cnt;
        remaining_n = remaining;
        mrd_addr_n  = mrd_addr;
        mrd_req_n   = mrd_req;
        req_ack_n   = 1'b0;
        unique case (state)
            ST_FLUSH: begin
                if (32'(flush_cnt) == FLUSH - 1) begin
                    state_n     = ST_IDLE;
                    flush_cnt_n = '0;
                end else begin
                    flush_cnt_n = flush_cnt + FW'(1);
                end
            end
            ST_IDLE: begin
                if (req && room) begin
                    req_ack_n   = 1'b1;
                    mrd_addr_n  = req_addr;
                    remaining_n = RW'(BURST);
                    mrd_req_n   = 1'b1;
                    state_n     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (grant) begin
                    mrd_addr_n  = mrd_addr + AN'(1);
                    remaining_n = remaining - RW'(1);
                    if (remaining == RW'(1)) begin
                        mrd_req_n = 1'b0;
                        state_n   = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_FLUSH;
        endcase
        busy_n = (state_n != ST_IDLE);
    end

    // Words in flight at memory: issued by grant, retired by a forwarded return.
    always_comb begin
        outstanding_n = outstanding;
        unique case ({grant, fwd})
            2'b10:   outstanding_n = outstanding + OW'(1);
            2'b01:   outstanding_n = outstanding - OW'(1);
            default: outstanding_n = outstanding;
        endcase
        mem_valid_n = fwd;
        mem_data_n  = mrd_valid ? mrd_data : mem_data;
    end

`ifdef TFT_RESP_STAT_EN
    always_ff @(posedge clkSYS or posedge aclr) begin
        if (aclr) begin
            burst_cnt <= '0;
        end else if (req_ack_n) begin
            burst_cnt <= burst_cnt + 16'd1;
        end
    end
`else
    assign burst_cnt = 16'h0;
`endif

endmodule
